// File: rtl/tx_clk_pkg.sv
// ----------------------------------------------------------------------------
// tx_clk_pkg
// Shared definitions for the TX clocking blocks.
//   lock_state_t     : states of the PLL lock supervisor
//   REFCLK_HZ        : free-running PLL reference clock frequency (73 MHz)
//   TX_PLL_RST_CYC   : default PLL reset pulse length, 1 us of refclk
//   TX_LOCK_TMO_CYC  : default lock timeout, 1 ms of refclk
//   TX_LOCK_STB_CYC  : default lock qualification window, 100 us of refclk
//   max3()           : largest of three values, used to size shared timers
// ----------------------------------------------------------------------------
package tx_clk_pkg;

   localparam int unsigned REFCLK_HZ       = 73_000_000;
   localparam int unsigned TX_PLL_RST_CYC  = REFCLK_HZ / 1_000_000;
   localparam int unsigned TX_LOCK_TMO_CYC = REFCLK_HZ / 1_000;
   localparam int unsigned TX_LOCK_STB_CYC = REFCLK_HZ / 10_000;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } lock_state_t;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer with asynchronous active-high reset. Brings
// a quasi-static signal into the clk domain; no multi-bit coherence is
// implied, each bit is synchronized independently.
//   clk : destination clock
//   rst : asynchronous reset, active-high, forces q (and the first stage)
//         to RST_VAL
//   d   : asynchronous input
//   q   : synchronized output, two clk edges of latency
// ----------------------------------------------------------------------------
module sync_2ff #(
   parameter int unsigned          WIDTH   = 1,
   parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= RST_VAL;
         q        <= RST_VAL;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/tx_pll_lock_seq.sv
// ----------------------------------------------------------------------------
// tx_pll_lock_seq
// Lock supervisor and reset sequencer for the TX clock PLL. Pulses the PLL
// reset, waits for lock, requires lock to stay up for a qualification window
// before releasing the TX-domain reset, and re-sequences the PLL on lock
// loss or lock timeout. Keeps lock-loss statistics.
//   refclk        : free-running PLL reference clock, the only clock
//   rst           : asynchronous active-high reset (also clears statistics)
//   pll_locked    : PLL lock indicator, asynchronous to refclk
//   clr_stats     : one-cycle pulse, clears lock_loss_cnt and timeout_err
//   pll_rst       : reset to the PLL, active-high
//   tx_rst        : reset to the TX domains, active-high
//   tx_ready      : high only while the PLL is qualified and running
//   lock_loss_cnt : saturating count of lock losses seen while running
//   timeout_err   : sticky flag, set whenever lock was not achieved in time
// ----------------------------------------------------------------------------
module tx_pll_lock_seq
   import tx_clk_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES      = TX_PLL_RST_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = TX_LOCK_TMO_CYC,
   parameter int unsigned LOCK_STABLE_CYCLES  = TX_LOCK_STB_CYC,
   parameter int unsigned CNT_W               = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             clr_stats,
   output logic             pll_rst,
   output logic             tx_rst,
   output logic             tx_ready,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic             timeout_err
);

   // One timer serves all three waits. It only ever reaches (limit - 1),
   // so $clog2 of the largest limit is always wide enough.
   localparam int unsigned TMR_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                          LOCK_STABLE_CYCLES);
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);

   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);

   logic              locked_s;
   lock_state_t       state_reg, state_next;
   logic [TMR_W-1:0]  timer_reg, timer_next;
   logic              loss_evt;
   logic              tmo_evt;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Next-state logic. Every transition clears the timer so each state
   // starts counting from zero; RUN holds it at zero for the same reason.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg + 1'b1;
      loss_evt   = 1'b0;
      tmo_evt    = 1'b0;
      case (state_reg)
         PLL_RST: begin
            if (timer_reg == RST_LAST) begin
               state_next = WAIT_LOCK;
               timer_next = '0;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_next = STABLE;
               timer_next = '0;
            end else if (timer_reg == TMO_LAST) begin
               state_next = PLL_RST;
               timer_next = '0;
               tmo_evt    = 1'b1;
            end
         end
         STABLE: begin
            // Any drop during qualification discards the accumulated
            // count; the timeout window restarts from zero as well.
            if (!locked_s) begin
               state_next = WAIT_LOCK;
               timer_next = '0;
            end else if (timer_reg == STB_LAST) begin
               state_next = RUN;
               timer_next = '0;
            end
         end
         RUN: begin
            timer_next = '0;
            if (!locked_s) begin
               state_next = PLL_RST;
               loss_evt   = 1'b1;
            end
         end
         default: begin
            state_next = PLL_RST;
            timer_next = '0;
         end
      endcase
   end

   // State, timer and registered outputs. Outputs are decoded from the next
   // state so they switch on the same edge as the state itself.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_reg     <= PLL_RST;
         timer_reg     <= '0;
         pll_rst       <= 1'b1;
         tx_rst        <= 1'b1;
         tx_ready      <= 1'b0;
         lock_loss_cnt <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         pll_rst   <= (state_next == PLL_RST);
         tx_rst    <= (state_next != RUN);
         tx_ready  <= (state_next == RUN);
         // A clear wins over a coincident event, which is then lost.
         if (clr_stats) begin
            lock_loss_cnt <= '0;
            timeout_err   <= 1'b0;
         end else begin
            if (loss_evt && (lock_loss_cnt != {CNT_W{1'b1}}))
               lock_loss_cnt <= lock_loss_cnt + 1'b1;
            if (tmo_evt)
               timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_pll_lock_seq.sv
// ----------------------------------------------------------------------------
// tb_tx_pll_lock_seq
// Scoreboard bench for tx_pll_lock_seq with PLL_RST_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=16. The stimulus process queues
// every output change it expects (edge number plus full output vector); the
// monitor samples on the falling edge and pops one entry for each change it
// observes. An observed change with nothing queued is an error too.
// Output vector layout: {pll_rst, tx_rst, tx_ready, timeout_err, cnt[7:0]}.
// ----------------------------------------------------------------------------
module tb_tx_pll_lock_seq;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       clr_stats;
   logic       pll_rst;
   logic       tx_rst;
   logic       tx_ready;
   logic [7:0] lock_loss_cnt;
   logic       timeout_err;

   typedef struct {
      int         cyc;
      logic [11:0] vec;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic [11:0] prev_vec = 'x;

   tx_pll_lock_seq #(
      .PLL_RST_CYCLES      (4),
      .LOCK_TIMEOUT_CYCLES (64),
      .LOCK_STABLE_CYCLES  (16),
      .CNT_W               (8)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .clr_stats     (clr_stats),
      .pll_rst       (pll_rst),
      .tx_rst        (tx_rst),
      .tx_ready      (tx_ready),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_err   (timeout_err)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   always @(posedge refclk) cyc = cyc + 1;

   // Monitor: one comparison per observed output change.
   always @(negedge refclk) begin
      logic [11:0] cur;
      exp_t        e;
      cur = {pll_rst, tx_rst, tx_ready, timeout_err, lock_loss_cnt};
      if (cur !== prev_vec) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_change: cyc=%0d outs=%b, no change queued",
                     cyc, cur);
         end else begin
            e = exp_q.pop_front();
            if ((e.cyc != cyc) || (cur !== e.vec)) begin
               errors = errors + 1;
               $display("FAIL %s: got cyc=%0d outs=%b, expected cyc=%0d outs=%b",
                        e.name, cyc, cur, e.cyc, e.vec);
            end else begin
               $display("check %s cyc=%0d outs=%b ok", e.name, cyc, cur);
            end
         end
         prev_vec = cur;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d changes pending",
               exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input int c, input logic pr, input logic tr,
                           input logic rdy, input logic terr,
                           input logic [7:0] cnt, input string nm);
      exp_t e;
      e.cyc  = c;
      e.vec  = {pr, tr, rdy, terr, cnt};
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Advance to 1 time unit after edge number c.
   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge refclk);
         #1;
      end
   endtask

   // Drop lock while in RUN. Loss is seen 2 edges after the first sampling
   // edge; PLL reset then lasts 4 edges. Optionally collide clr_stats with
   // the loss edge.
   task automatic drop_lock(input logic [7:0] cnt, input logic terr,
                            input bit clr);
      int n;
      n = cyc;
      pll_locked = 1'b0;
      push_exp(n + 3, 1'b1, 1'b1, 1'b0, terr, cnt, "loss_hit");
      push_exp(n + 7, 1'b0, 1'b1, 1'b0, terr, cnt, "loss_pll_rst_fall");
      if (clr) begin
         wait_to(n + 2);
         clr_stats = 1'b1;
         wait_to(n + 3);
         clr_stats = 1'b0;
      end
      wait_to(n + 7);
   endtask

   // Raise lock in WAIT_LOCK; release 19 edges after the rise point, or
   // 20 edges after a one-cycle glitch placed 10 edges into the wait.
   task automatic relock(input logic terr, input logic [7:0] cnt,
                         input bit glitch);
      int r;
      int d;
      int run_c;
      r = cyc;
      pll_locked = 1'b1;
      if (glitch) begin
         wait_to(r + 10);
         d = cyc;
         pll_locked = 1'b0;
         wait_to(d + 1);
         pll_locked = 1'b1;
         run_c = d + 20;
      end else begin
         run_c = r + 19;
      end
      push_exp(run_c, 1'b0, 1'b0, 1'b1, terr, cnt,
               glitch ? "flaky_release" : "release");
      wait_to(run_c + 2);
   endtask

   initial begin
      int c;
      logic [7:0] sat;
      rst        = 1'b1;
      pll_locked = 1'b0;
      clr_stats  = 1'b0;
      push_exp(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "reset_state");
      repeat (3) @(posedge refclk);
      #1;
      rst = 1'b0;

      // Timeout: pll_rst high 4 edges, 64-cycle waits, period 68.
      push_exp(7,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "pll_rst_first_fall");
      push_exp(71,  1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "timeout_1");
      push_exp(75,  1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "timeout_1_pll_rst_fall");
      push_exp(139, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "timeout_2");
      push_exp(143, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "timeout_2_pll_rst_fall");
      wait_to(153);

      // Normal lock 10 cycles after pll_rst fell.
      pll_locked = 1'b1;
      push_exp(172, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, "normal_release");
      wait_to(174);

      // Loss in RUN, then relock.
      drop_lock(8'd1, 1'b1, 1'b0);
      relock(1'b1, 8'd1, 1'b0);

      // Loss, then a one-cycle glitch during qualification.
      drop_lock(8'd2, 1'b1, 1'b0);
      relock(1'b1, 8'd2, 1'b1);

      // clr_stats on the loss edge: both statistics end up cleared.
      drop_lock(8'd0, 1'b0, 1'b1);
      relock(1'b0, 8'd0, 1'b0);

      // Saturation of the loss counter.
      for (int i = 1; i <= 300; i++) begin
         sat = (i > 255) ? 8'd255 : 8'(i);
         drop_lock(sat, 1'b0, 1'b0);
         relock(1'b0, sat, 1'b0);
      end

      // Asynchronous reset in the middle of qualification.
      drop_lock(8'd255, 1'b0, 1'b0);
      pll_locked = 1'b1;
      wait_to(cyc + 8);
      c = cyc;
      push_exp(c, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "async_reset");
      rst = 1'b1;
      wait_to(c + 2);
      rst = 1'b0;
      push_exp(c + 6,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "restart_pll_rst_fall");
      push_exp(c + 23, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, "restart_release");
      wait_to(c + 26);

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL pending_changes: got %0d never observed, expected 0 (next %s at cyc %0d)",
                  exp_q.size(), exp_q[0].name, exp_q[0].cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
